imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 119 +++++++++++
 tb/tb_imem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of an asynchronous-read instruction memory.
// Fetch has priority; the debug/loader port is forced a grant after STARVE_LIMIT denials.
module imem_arbiter #(
    parameter int unsigned MEM_DEPTH    = 1024,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        f_req_valid,
    input  logic [31:0] f_req_addr,
    output logic        f_req_ready,
    output logic        f_rsp_valid,
    output logic [31:0] f_rsp_data,
    output logic        f_rsp_err,
    input  logic        f_rsp_ready,

    input  logic        d_req_valid,
    input  logic [31:0] d_req_addr,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    input  logic        d_rsp_ready,

    output logic [31:0] mem_addr,
    input  logic [31:0] mem_dout
);

    localparam int unsigned CntWidth = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CntWidth-1:0] StarveMax = CntWidth'(STARVE_LIMIT);
    // One bit wider than an address so MEM_DEPTH*4 cannot wrap.
    localparam logic [32:0] AddrLimit = 33'(MEM_DEPTH) * 33'd4;

    logic                f_elig;
    logic                d_elig;
    logic                f_gnt;
    logic                d_gnt;
    logic                d_forced;
    logic                addr_fault;
    logic [31:0]         rsp_word;
    logic [CntWidth-1:0] starve_cnt;
    logic [CntWidth-1:0] starve_cnt_next;

    // A port may take the slot only if its response register frees up this cycle.
    // Gating with reset keeps both ready outputs low while reset is asserted.
    always_comb begin
        f_elig   = reset & f_req_valid & (~f_rsp_valid | f_rsp_ready);
        d_elig   = reset & d_req_valid & (~d_rsp_valid | d_rsp_ready);
        d_forced = (starve_cnt == StarveMax);
        d_gnt    = d_elig & (~f_elig | d_forced);
        f_gnt    = f_elig & ~d_gnt;
    end

    assign f_req_ready = f_gnt;
    assign d_req_ready = d_gnt;

    always_comb begin
        mem_addr = 32'h0;
        if (f_gnt) begin
            mem_addr = f_req_addr;
        end else if (d_gnt) begin
            mem_addr = d_req_addr;
        end
    end

    always_comb begin
        addr_fault = (mem_addr[1:0] != 2'b00) || ({1'b0, mem_addr} >= AddrLimit);
        rsp_word   = addr_fault ? 32'h0 : mem_dout;
    end

    // Saturating count of cycles debug was eligible but lost the slot.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (!d_req_valid || d_gnt) begin
            starve_cnt_next = '0;
        end else if (d_elig && (starve_cnt != StarveMax)) begin
            starve_cnt_next = starve_cnt + CntWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_next;
        end
    end

    // A grant overwrites the slot; otherwise the response holds until accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_rsp_valid <= 1'b0;
            f_rsp_data  <= 32'h0;
            f_rsp_err   <= 1'b0;
        end else if (f_gnt) begin
            f_rsp_valid <= 1'b1;
            f_rsp_data  <= rsp_word;
            f_rsp_err   <= addr_fault;
        end else if (f_rsp_ready) begin
            f_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_rsp_valid <= 1'b0;
            d_rsp_data  <= 32'h0;
            d_rsp_err   <= 1'b0;
        end else if (d_gnt) begin
            d_rsp_valid <= 1'b1;
            d_rsp_data  <= rsp_word;
            d_rsp_err   <= addr_fault;
        end else if (d_rsp_ready) begin
            d_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: a reference model predicts grants and
// queues expected responses, which are compared when the DUT presents them.
module tb_imem_arbiter;

    localparam int unsigned MemDepth    = 1024;
    localparam int unsigned StarveLimit = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_err, f_rsp_ready;
    logic [31:0] f_req_addr, f_rsp_data;
    logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_err, d_rsp_ready;
    logic [31:0] d_req_addr, d_rsp_data;
    logic [31:0] mem_addr, mem_dout;

    logic [31:0] mem_model [MemDepth];
    logic [32:0] f_q [$];
    logic [32:0] d_q [$];

    int n_checks = 0;
    int n_errors = 0;

    bit m_fv, m_dv;
    int m_cnt;

    always #5 clk = ~clk;

    assign mem_dout = mem_model[mem_addr[11:2]];

    imem_arbiter #(
        .MEM_DEPTH    (MemDepth),
        .STARVE_LIMIT (StarveLimit)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .f_req_valid (f_req_valid),
        .f_req_addr  (f_req_addr),
        .f_req_ready (f_req_ready),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_data  (f_rsp_data),
        .f_rsp_err   (f_rsp_err),
        .f_rsp_ready (f_rsp_ready),
        .d_req_valid (d_req_valid),
        .d_req_addr  (d_req_addr),
        .d_req_ready (d_req_ready),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_data  (d_rsp_data),
        .d_rsp_err   (d_rsp_err),
        .d_rsp_ready (d_rsp_ready),
        .mem_addr    (mem_addr),
        .mem_dout    (mem_dout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {err, data} a correct memory returns for a byte address.
    function automatic logic [32:0] expect_rsp(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a >= MemDepth * 4) return {1'b1, 32'h0};
        return {1'b0, mem_model[a[11:2]]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_f_rsp_valid"}, 32'(f_rsp_valid), 32'h0);
        check_eq({tag, "_f_rsp_data"},  f_rsp_data,       32'h0);
        check_eq({tag, "_f_rsp_err"},   32'(f_rsp_err),   32'h0);
        check_eq({tag, "_d_rsp_valid"}, 32'(d_rsp_valid), 32'h0);
        check_eq({tag, "_d_rsp_data"},  d_rsp_data,       32'h0);
        check_eq({tag, "_d_rsp_err"},   32'(d_rsp_err),   32'h0);
        check_eq({tag, "_f_req_ready"}, 32'(f_req_ready), 32'h0);
        check_eq({tag, "_d_req_ready"}, 32'(d_req_ready), 32'h0);
        check_eq({tag, "_mem_addr"},    mem_addr,         32'h0);
        check_eq({tag, "_starve_cnt"},  32'(dut.starve_cnt), 32'h0);
    endtask

    task automatic model_reset();
        m_fv = 0;
        m_dv = 0;
        m_cnt = 0;
        f_q.delete();
        d_q.delete();
    endtask

    // One clock cycle: called just after a rising edge, returns just after the next one.
    // Outputs the DUT's observed req_ready values for directed checks.
    task automatic cycle(input logic fv, input logic [31:0] fa, input logic fr,
                         input logic dv, input logic [31:0] da, input logic dr,
                         output logic fg_obs, output logic dg_obs);
        logic [32:0] e;
        bit f_ok, d_ok, fg, dg;
        f_req_valid = fv; f_req_addr = fa; f_rsp_ready = fr;
        d_req_valid = dv; d_req_addr = da; d_rsp_ready = dr;
        @(negedge clk);
        check_eq("f_rsp_valid", 32'(f_rsp_valid), 32'(m_fv));
        check_eq("d_rsp_valid", 32'(d_rsp_valid), 32'(m_dv));
        if (m_fv) begin
            check_eq("f_sb_nonempty", 32'(f_q.size() != 0), 32'h1);
            if (f_q.size() != 0) begin
                e = f_q[0];
                check_eq("f_rsp_data", f_rsp_data, e[31:0]);
                check_eq("f_rsp_err", 32'(f_rsp_err), 32'(e[32]));
                if (fr) void'(f_q.pop_front());
            end
        end
        if (m_dv) begin
            check_eq("d_sb_nonempty", 32'(d_q.size() != 0), 32'h1);
            if (d_q.size() != 0) begin
                e = d_q[0];
                check_eq("d_rsp_data", d_rsp_data, e[31:0]);
                check_eq("d_rsp_err", 32'(d_rsp_err), 32'(e[32]));
                if (dr) void'(d_q.pop_front());
            end
        end
        f_ok = fv && (!m_fv || fr);
        d_ok = dv && (!m_dv || dr);
        dg = d_ok && (!f_ok || m_cnt >= StarveLimit);
        fg = f_ok && !dg;
        check_eq("f_req_ready", 32'(f_req_ready), 32'(fg));
        check_eq("d_req_ready", 32'(d_req_ready), 32'(dg));
        check_eq("mem_addr", mem_addr, fg ? fa : (dg ? da : 32'h0));
        check_eq("starve_cnt", 32'(dut.starve_cnt), 32'(m_cnt));
        fg_obs = f_req_ready;
        dg_obs = d_req_ready;
        if (fg) f_q.push_back(expect_rsp(fa));
        if (dg) d_q.push_back(expect_rsp(da));
        @(posedge clk);
        if (fg) m_fv = 1; else if (fr) m_fv = 0;
        if (dg) m_dv = 1; else if (dr) m_dv = 0;
        if (!dv || dg) m_cnt = 0;
        else if (d_ok && m_cnt < StarveLimit) m_cnt++;
        #1;
    endtask

    initial begin
        logic fg, dg;
        logic [31:0] fa, da;
        for (int i = 0; i < MemDepth; i++) mem_model[i] = $urandom | 32'h1;
        model_reset();

        // Reset with requests pending: nothing may be granted.
        reset = 1'b0;
        f_req_valid = 1'b1; f_req_addr = 32'h4; f_rsp_ready = 1'b1;
        d_req_valid = 1'b1; d_req_addr = 32'h8; d_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 check_reset_outputs("rst");
        @(posedge clk);
        #2 reset = 1'b1;

        // Fetch-only stream, first grant right after reset release.
        cycle(1, 32'h0, 1, 0, 32'h0, 1, fg, dg);
        check_eq("first_grant", 32'(fg), 32'h1);
        cycle(1, 32'h4, 1, 0, 32'h0, 1, fg, dg);
        cycle(1, 32'h8, 1, 0, 32'h0, 1, fg, dg);
        cycle(0, 32'h0, 1, 0, 32'h0, 1, fg, dg);

        // Both request continuously: debug wins every fifth cycle.
        for (int i = 0; i < 10; i++) begin
            cycle(1, 32'h10, 1, 1, 32'h20, 1, fg, dg);
            check_eq("starve_pattern_d", 32'(dg), 32'((i % 5) == 4));
            check_eq("starve_pattern_f", 32'(fg), 32'((i % 5) != 4));
        end
        cycle(0, 32'h0, 1, 0, 32'h0, 1, fg, dg);

        // Faults and range boundary on the debug port, one fetch fault.
        cycle(0, 32'h0, 1, 1, 32'h6,    1, fg, dg);
        cycle(0, 32'h0, 1, 1, 32'h1000, 1, fg, dg);
        cycle(0, 32'h0, 1, 1, 32'hFFC,  1, fg, dg);
        cycle(1, 32'h3, 1, 0, 32'h0,    1, fg, dg);
        cycle(0, 32'h0, 1, 0, 32'h0,    1, fg, dg);
        check_eq("fault_d_err", 32'(d_rsp_err), 32'h0);

        // Backpressure on fetch: debug takes the slot, fetch regranted on release.
        cycle(1, 32'h40, 1, 0, 32'h0, 1, fg, dg);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 32'h44, 0, 1, 32'h50 + 32'(i * 4), 1, fg, dg);
            check_eq("bp_f_blocked", 32'(fg), 32'h0);
            check_eq("bp_d_granted", 32'(dg), 32'h1);
        end
        cycle(1, 32'h44, 1, 0, 32'h0, 1, fg, dg);
        check_eq("bp_f_regrant", 32'(fg), 32'h1);
        cycle(0, 32'h0, 1, 0, 32'h0, 1, fg, dg);

        // Randomised traffic; addresses held until granted.
        fa = 32'h0;
        da = 32'h0;
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0, fa, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, da, $urandom_range(0, 3) != 0, fg, dg);
            if (fg) fa = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 32'h1100)
                                                     : 32'($urandom_range(0, 1100)) << 2;
            if (dg) da = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 32'h1100)
                                                     : 32'($urandom_range(0, 1100)) << 2;
        end
        cycle(0, 32'h0, 1, 0, 32'h0, 1, fg, dg);

        // Mid-transaction reset discards a held fetch response.
        cycle(1, 32'h8, 1, 1, 32'hC, 0, fg, dg);
        cycle(0, 32'h0, 0, 1, 32'hC, 0, fg, dg);
        check_eq("mid_pre_valid", 32'(f_rsp_valid), 32'h1);
        f_req_valid = 1'b1;
        #2 reset = 1'b0;
        #1 check_reset_outputs("mid");
        model_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        cycle(1, 32'h0, 1, 0, 32'h0, 1, fg, dg);
        check_eq("mid_regrant", 32'(fg), 32'h1);
        cycle(0, 32'h0, 1, 0, 32'h0, 1, fg, dg);
        cycle(0, 32'h0, 1, 0, 32'h0, 1, fg, dg);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
